timer_ctrl: RTL and testbench

Programmable interval timer and controller for the D16i clock-prescale path. It owns a power-of-two tick generator and sequences a down-counter from a reload value. It raises an expiry interrupt and exposes a small memory-mapped register file to the CPU bus. It runs in one-shot or periodic mode and sits beside the interrupt controller on the peripheral bus.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_ctrl_tick_gen.sv | 30 +++
 rtl/timer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_timer_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and register map for the programmable interval timer.
// Holds the FSM state encoding, register addresses and CTRL/STATUS bit positions.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_RELOAD = 3'd1;
   localparam logic [2:0] ADDR_COUNT  = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_CMP    = 3'd4;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE    = 1;
   localparam int CTRL_IE      = 2;
   localparam int CTRL_DIV_LSB = 4;
   localparam int CTRL_DIV_MSB = 8;

   localparam int STAT_EXPIRED = 0;
   localparam int STAT_RUNNING = 1;

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Power-of-two prescaler: 32-bit free-running counter, tick when the low DIV bits are all ones.
// clear has priority over en so a reload always restarts the prescale phase.
module tick_gen #(
   parameter int DIV_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [31:0] pre;
   logic [31:0] mask;

   assign mask = (32'd1 << div) - 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pre <= '0;
      else if (clear)
         pre <= '0;
      else if (en)
         pre <= pre + 32'd1;
   end

   assign tick = en && ((pre & mask) == mask);

endmodule

// File: rtl/timer_ctrl.sv
// Interval timer with bus register file, one-shot/periodic down-counter and sticky expiry irq.
// Optional PWM compare output and CMP register are built when TIMER_PWM_EN is defined.
//
//   state | meaning
//   IDLE  | stopped, COUNT and prescaler frozen
//   LOAD  | one cycle: COUNT <= RELOAD, prescaler cleared
//   RUN   | counting down on each prescaler tick
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIV_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs,
   input  logic             we,
   input  logic [2:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             irq,
   input  logic             irq_ack
`ifdef TIMER_PWM_EN
   ,
   output logic             pwm_out
`endif
);

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic             ctrl_en, ctrl_mode, ctrl_ie;
   logic [DIV_W-1:0] ctrl_div;
   logic [WIDTH-1:0] reload, count;
   logic             expired;
   logic             tick, run_st;
   logic             ctrl_wr, reload_wr, stat_wr;
   logic             pre_clr, load_cnt, dec_cnt, set_exp, clr_en;
   logic [WIDTH-1:0] rd_data;

   assign ctrl_wr   = cs && we && (addr == ADDR_CTRL);
   assign reload_wr = cs && we && (addr == ADDR_RELOAD);
   assign stat_wr   = cs && we && (addr == ADDR_STATUS);
   assign run_st    = (state == RUN);

   tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (pre_clr),
      .en    (run_st),
      .div   (ctrl_div),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pre_clr   = 1'b0;
      load_cnt  = 1'b0;
      dec_cnt   = 1'b0;
      set_exp   = 1'b0;
      clr_en    = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_wr && wdata[CTRL_EN])
               state_nxt = LOAD;
         end
         LOAD: begin
            pre_clr  = 1'b1;
            load_cnt = 1'b1;
            state_nxt = (ctrl_wr && !wdata[CTRL_EN]) ? IDLE : RUN;
         end
         RUN: begin
            // a stop request wins over a coincident tick so COUNT freezes where it was
            if (ctrl_wr && !wdata[CTRL_EN]) begin
               state_nxt = IDLE;
            end else if (tick) begin
               if (count != '0) begin
                  dec_cnt = 1'b1;
               end else begin
                  set_exp = 1'b1;
                  if (ctrl_mode) begin
                     load_cnt = 1'b1;
                  end else begin
                     clr_en    = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 1'b0;
         ctrl_ie   <= 1'b0;
         ctrl_div  <= '0;
         reload    <= '0;
         count     <= '0;
         expired   <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ctrl_en   <= wdata[CTRL_EN];
            ctrl_mode <= wdata[CTRL_MODE];
            ctrl_ie   <= wdata[CTRL_IE];
            ctrl_div  <= wdata[CTRL_DIV_LSB +: DIV_W];
         end
         if (clr_en)
            ctrl_en <= 1'b0;
         if (reload_wr)
            reload <= wdata;
         if (load_cnt)
            count <= reload;
         else if (dec_cnt)
            count <= count - CNT_ONE;
         if (set_exp)
            expired <= 1'b1;
         else if (irq_ack || (stat_wr && wdata[STAT_EXPIRED]))
            expired <= 1'b0;
      end
   end

`ifdef TIMER_PWM_EN
   logic [WIDTH-1:0] cmp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp     <= '0;
         pwm_out <= 1'b0;
      end else begin
         if (cs && we && (addr == ADDR_CMP))
            cmp <= wdata;
         pwm_out <= run_st && (count < cmp);
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_CTRL: begin
            rd_data[CTRL_EN]                  = ctrl_en;
            rd_data[CTRL_MODE]                = ctrl_mode;
            rd_data[CTRL_IE]                  = ctrl_ie;
            rd_data[CTRL_DIV_LSB +: DIV_W]    = ctrl_div;
         end
         ADDR_RELOAD: rd_data = reload;
         ADDR_COUNT:  rd_data = count;
         ADDR_STATUS: begin
            rd_data[STAT_EXPIRED] = expired;
            rd_data[STAT_RUNNING] = (state != IDLE);
         end
`ifdef TIMER_PWM_EN
         ADDR_CMP:    rd_data = cmp;
`endif
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rdata <= '0;
      else if (cs && !we)
         rdata <= rd_data;
   end

   assign irq = ctrl_ie && expired;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed and randomized checks of timer_ctrl against an arithmetic model of expiry timing
// (expiry edge = load edge + (RELOAD+1)*2^DIV, COUNT = RELOAD - floor(elapsed/2^DIV)).
module tb_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  addr = 3'd0;
   logic [15:0] wdata = 16'd0;
   logic [15:0] rdata;
   logic        irq;
   logic        irq_ack = 1'b0;
`ifdef TIMER_PWM_EN
   logic        pwm_out;
`endif

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;

   timer_ctrl #(.WIDTH(16), .DIV_W(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .cs      (cs),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq     (irq),
      .irq_ack (irq_ack)
`ifdef TIMER_PWM_EN
      ,
      .pwm_out (pwm_out)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All bus tasks start and end on a falling edge; edge_idx is the rising edge that samples cs.
   task automatic bus_wr(input logic [2:0] a, input logic [15:0] d, output int edge_idx);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      edge_idx = cyc + 1;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [15:0] d, output int edge_idx);
      cs = 1'b1; we = 1'b0; addr = a;
      edge_idx = cyc + 1;
      @(negedge clk);
      cs = 1'b0;
      d = rdata;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin
      int w, x, e1, ex, r, d, ie, s, hi;
      logic [15:0] v;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_irq", irq, 1'b0);
      check("rst_rdata", rdata, 16'h0);

      // unused address and read-only COUNT ignore writes
      bus_wr(3'd5, 16'hFFFF, w);
      bus_rd(3'd5, v, x);
      check("addr5_rd", v, 16'h0);
      bus_wr(3'd2, 16'h1234, w);
      bus_rd(3'd2, v, x);
      check("count_ro", v, 16'h0);

      // async reset mid-run with irq high
      bus_wr(3'd1, 16'd5, w);
      bus_wr(3'd0, 16'h0007, w);
      ex = w + 1 + 6;
      bus_rd(3'd1, v, x);
      check("reload_rd", v, 16'd5);
      wait_to(ex);
      check("pre_rst_irq", irq, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_irq", irq, 1'b0);
      check("async_rst_rdata", rdata, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 5; a++) begin
         bus_rd(a[2:0], v, x);
         check($sformatf("post_rst_reg%0d", a), v, 16'h0);
      end

      // one-shot RELOAD=3 DIV=0
      bus_wr(3'd1, 16'd3, w);
      bus_wr(3'd0, 16'h0005, w);
      wait_to(w + 4);
      check("os_irq_before", irq, 1'b0);
      @(negedge clk);
      check("os_irq_at", irq, 1'b1);
      bus_rd(3'd3, v, x);
      check("os_status", v, 16'h0001);
      bus_rd(3'd0, v, x);
      check("os_ctrl", v, 16'h0004);
      bus_rd(3'd2, v, x);
      check("os_count", v, 16'h0);
      bus_wr(3'd3, 16'h0001, w);
      check("os_stat_clr_irq", irq, 1'b0);

      // periodic RELOAD=1 DIV=2: expiry every 8 cycles, acked in between
      bus_wr(3'd1, 16'd1, w);
      bus_wr(3'd0, 16'h0027, w);
      e1 = w + 1;
      for (int k = 1; k <= 3; k++) begin
         ex = e1 + 8 * k;
         wait_to(ex - 1);
         check($sformatf("per%0d_before", k), irq, 1'b0);
         @(negedge clk);
         check($sformatf("per%0d_at", k), irq, 1'b1);
         irq_ack = 1'b1;
         @(negedge clk);
         irq_ack = 1'b0;
         check($sformatf("per%0d_ack", k), irq, 1'b0);
      end
      // ack on the same edge as an expiry: set wins
      ex = e1 + 32;
      wait_to(ex - 1);
      irq_ack = 1'b1;
      check("sim_before", irq, 1'b0);
      @(negedge clk);
      irq_ack = 1'b0;
      check("sim_at", irq, 1'b1);
      @(negedge clk);
      check("sim_after", irq, 1'b1);
      bus_rd(3'd3, v, x);
      check("sim_status", v, 16'h0003);
      bus_wr(3'd0, 16'h0000, w);
      bus_wr(3'd3, 16'h0001, w);

      // stop at COUNT=6, hold, then re-enable reloads
      bus_wr(3'd1, 16'd10, w);
      bus_wr(3'd0, 16'h0007, w);
      e1 = w + 1;
      wait_to(e1 + 4);
      bus_wr(3'd0, 16'h0006, s);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k % 5 == 4) check($sformatf("stop_irq%0d", k), irq, 1'b0);
      end
      bus_rd(3'd2, v, x);
      check("stop_count", v, 16'd6);
      bus_rd(3'd3, v, x);
      check("stop_status", v, 16'h0000);
      bus_wr(3'd0, 16'h0007, w);
      @(negedge clk);
      bus_rd(3'd2, v, x);
      check("resume_count", v, 16'd10);
      bus_wr(3'd0, 16'h0000, w);

      // randomized one-shot runs against the timing model
      for (int it = 0; it < 6; it++) begin
         r  = $urandom_range(1, 6);
         d  = $urandom_range(0, 2);
         ie = $urandom_range(0, 1);
         bus_wr(3'd1, r[15:0], w);
         bus_wr(3'd0, 16'(1 | (ie << 2) | (d << 4)), w);
         e1 = w + 1;
         ex = e1 + ((r + 1) << d);
         x  = $urandom_range(e1 + 1, ex - 1);
         wait_to(x - 1);
         bus_rd(3'd2, v, x);
         check($sformatf("rnd%0d_count", it), v, 16'(r - ((x - 1 - e1) >> d)));
         wait_to(ex - 1);
         check($sformatf("rnd%0d_irq_before", it), irq, 1'b0);
         @(negedge clk);
         check($sformatf("rnd%0d_irq_at", it), irq, ie[0]);
         bus_rd(3'd3, v, x);
         check($sformatf("rnd%0d_status", it), v, 16'h0001);
         bus_rd(3'd0, v, x);
         check($sformatf("rnd%0d_ctrl", it), v, 16'((ie << 2) | (d << 4)));
         irq_ack = 1'b1;
         @(negedge clk);
         irq_ack = 1'b0;
         bus_rd(3'd3, v, x);
         check($sformatf("rnd%0d_ack", it), v, 16'h0000);
      end

`ifdef TIMER_PWM_EN
      // PWM: RELOAD=7 CMP=3 periodic -> high 3 of every 8 cycles
      bus_wr(3'd1, 16'd7, w);
      bus_wr(3'd4, 16'd3, w);
      bus_wr(3'd0, 16'h0003, w);
      repeat (4) @(negedge clk);
      hi = 0;
      for (int k = 0; k < 16; k++) begin
         if (pwm_out) hi++;
         @(negedge clk);
      end
      check("pwm_duty", hi, 6);
      bus_wr(3'd4, 16'd0, w);
      repeat (2) @(negedge clk);
      hi = 0;
      for (int k = 0; k < 16; k++) begin
         if (pwm_out) hi++;
         @(negedge clk);
      end
      check("pwm_cmp0", hi, 0);
      bus_wr(3'd0, 16'h0000, w);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
